adder_share_arbiter_20b: RTL and testbench

ADDER_SHARE_ARBITER_20B -- requirements
Module: adder_share_arbiter_20b

---
 rtl/adder_share_arbiter_20b.sv | 185 ++++++++++++++++++
 tb/tb_adder_share_arbiter_20b.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter_20b.sv
// adder_share_arbiter_20b
//   Two requesters share one 2-cycle pipelined 20-bit adder. A round-robin
//   arbiter grants at most one requester per cycle; a 2-entry tag pipeline
//   runs beside the adder so each result returns as a one-cycle strobe to
//   the requester that issued it. Per-requester completion counters wrap.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   reqN_valid/a/b, reqN_ready  requester N operand handshake (N = 0, 1)
//   rspN_valid, rsp_sum       result strobe for requester N, shared W+1 sum
//   busy                      an operation is in flight in the adder
//   cnt0, cnt1                completed operations per requester (wrapping)
//
// pipe_carry_select_adder_20b
//   Two-stage 20-bit adder: stage 1 adds the low 10 bits, stage 2 adds the
//   high 10 bits for both carry-in values and picks one with the low carry.
//   Operands presented in cycle k produce sum in cycle k+2.
//
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   a, b, cin   operands and carry-in
//   sum         registered 21-bit result

module pipe_carry_select_adder_20b (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] a,
    input  logic [19:0] b,
    input  logic        cin,
    output logic [20:0] sum
);

    logic [10:0] lo_full;
    logic [9:0]  lo_sum_d, lo_sum_q;
    logic        lo_c_d,   lo_c_q;
    logic [9:0]  a_hi_d,   a_hi_q;
    logic [9:0]  b_hi_d,   b_hi_q;
    logic [10:0] hi_c0;
    logic [10:0] hi_c1;
    logic [20:0] sum_d,    sum_q;

    always_comb begin
        lo_full  = {1'b0, a[9:0]} + {1'b0, b[9:0]} + {10'd0, cin};
        lo_sum_d = lo_full[9:0];
        lo_c_d   = lo_full[10];
        a_hi_d   = a[19:10];
        b_hi_d   = b[19:10];
    end

    // Both high-half candidates are formed in parallel; the registered low
    // carry only drives the final select.
    always_comb begin
        hi_c0 = {1'b0, a_hi_q} + {1'b0, b_hi_q};
        hi_c1 = hi_c0 + 11'd1;
        sum_d = lo_c_q ? {hi_c1, lo_sum_q} : {hi_c0, lo_sum_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_sum_q <= '0;
            lo_c_q   <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            sum_q    <= '0;
        end else begin
            lo_sum_q <= lo_sum_d;
            lo_c_q   <= lo_c_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            sum_q    <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// Arbitration state (last_q)
//   state | meaning
//   0     | requester 0 granted most recently; requester 1 wins next tie
//   1     | requester 1 granted most recently (reset); requester 0 wins next tie
module adder_share_arbiter_20b #(
    parameter int W     = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [W:0]       rsp_sum,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             last_d, last_q;
    logic             gnt0, gnt1;
    logic [W-1:0]     op_a, op_b;
    logic [1:0]       tag0_d, tag0_q;   // {valid, requester id}
    logic [1:0]       tag1_d, tag1_q;
    logic [CNT_W-1:0] cnt0_d, cnt0_q;
    logic [CNT_W-1:0] cnt1_d, cnt1_q;
    logic [W:0]       add_sum;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
            tag0_q <= '0;
            tag1_q <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            last_q <= last_d;
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Grant / next-state. rstn gates the grants so nothing is accepted
    // while reset is held, even though the flops are already cleared.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        last_d = last_q;
        if (gnt0)      last_d = 1'b0;
        else if (gnt1) last_d = 1'b1;
        tag0_d = {gnt0 | gnt1, gnt1};
        tag1_d = tag0_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (tag1_q[1] && !tag1_q[0]) cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (tag1_q[1] &&  tag1_q[0]) cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Outputs
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (gnt0) begin
            op_a = req0_a;
            op_b = req0_b;
        end else if (gnt1) begin
            op_a = req1_a;
            op_b = req1_b;
        end
        req0_ready = gnt0;
        req1_ready = gnt1;
        rsp0_valid = tag1_q[1] && !tag1_q[0];
        rsp1_valid = tag1_q[1] &&  tag1_q[0];
        rsp_sum    = add_sum;
        busy       = tag0_q[1] | tag1_q[1];
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

    pipe_carry_select_adder_20b u_adder (
        .clk  (clk),
        .rstn (rstn),
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum)
    );

endmodule

// File: tb/tb_adder_share_arbiter_20b.sv
module tb_adder_share_arbiter_20b;

    localparam int W     = 20;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req0_valid = 1'b0;
    logic [W-1:0]     req0_a = '0;
    logic [W-1:0]     req0_b = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [W-1:0]     req1_a = '0;
    logic [W-1:0]     req1_b = '0;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [W:0]       rsp_sum;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    adder_share_arbiter_20b #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_sum    (rsp_sum),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [W:0] sum;
        int         due;
    } sb_t;

    sb_t              sb_q[$];
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic             m_last = 1'b1;
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check grants against the
    // round-robin model, and queue the expected result of any transfer.
    task automatic drive(input logic rst_v,
                         input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        logic g0, g1;
        sb_t  e;
        @(negedge clk);
        rstn = rst_v;
        if (!rst_v) begin
            sb_q.delete();
            m_last = 1'b1;
        end
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_v) begin
            if (v0 && v1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        if (g0 || g1) begin
            e.id  = g1;
            e.sum = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            e.due = cyc + 2;
            sb_q.push_back(e);
            m_last = g1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Response monitor: sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        sb_t e;
        logic exp_busy;
        cyc++;
        #2;
        if (!rstn) begin
            m_cnt0 = '0;
            m_cnt1 = '0;
            chk("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
            chk("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
            chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        end else begin
            chk("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
            chk("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
            exp_busy = (sb_q.size() > 0) && (sb_q[0].due <= cyc + 1);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q[0];
                sb_q.pop_front();
                chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, !e.id});
                chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e.id});
                chk("rsp_sum", {11'd0, rsp_sum}, {11'd0, e.sum});
                if (e.id) m_cnt1 = m_cnt1 + 1'b1;
                else      m_cnt0 = m_cnt0 + 1'b1;
            end else begin
                chk("no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end
        end
    end

    logic [CNT_W-1:0] cnt0_before;

    initial begin
        // Reset, then single request on the first cycle after release
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 20'h1, 20'h2, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 20'h00001, 20'h00002, 1'b0, '0, '0);
        idle(4);
        chk("single_cnt0", {16'd0, cnt0}, 32'd1);

        // Tie: both valid for 4 cycles -> 0,1,0,1
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 20'h10 + 20'(i), 20'h100, 1'b1, 20'h20 + 20'(i), 20'h200);
        idle(4);
        chk("tie_cnt0", {16'd0, cnt0}, 32'd2);
        chk("tie_cnt1", {16'd0, cnt1}, 32'd2);

        // Carry-out on requester 1, and mixed valid patterns
        drive(1'b1, 1'b0, '0, '0, 1'b1, 20'hFFFFF, 20'hFFFFF);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 20'hFFFFF, 20'h00001);
        drive(1'b1, 1'b1, 20'h12345, 20'h6789A, 1'b1, 20'hABCDE, 20'h11111);
        drive(1'b1, 1'b1, 20'h80000, 20'h80000, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 20'h00000, 20'h00000, 1'b1, 20'h7FFFF, 20'h00001);
        idle(4);

        // Stream: 100 back-to-back random pairs on requester 0
        cnt0_before = m_cnt0;
        for (int i = 0; i < 100; i++)
            drive(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, '0, '0);
        idle(4);
        chk("stream_cnt0", {16'd0, cnt0}, {16'd0, cnt0_before + 16'd100});

        // Reset mid-flight: transfer in k, reset held during k+1
        drive(1'b1, 1'b1, 20'h55555, 20'h22222, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 20'h33333, 20'h44444, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        idle(5);
        chk("midrst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("midrst_cnt1", {16'd0, cnt1}, 32'd0);

        // Counter wrap: 3 ops on req0, then 2^CNT_W ops on req1
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 20'(i), 20'h1, 1'b0, '0, '0);
        for (int i = 0; i < (1 << CNT_W); i++)
            drive(1'b1, 1'b0, '0, '0, 1'b1, 20'(i), 20'(i * 3));
        idle(4);
        chk("wrap_cnt1", {16'd0, cnt1}, 32'd0);
        chk("wrap_cnt0", {16'd0, cnt0}, 32'd3);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
